// File: rtl/mc_mem_responder.sv
// Word-addressed memory responder for a multicycle core: accepts one request,
// waits WAIT_CYCLES, then holds a registered response until it is consumed.
module mc_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_next;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [DEPTH];
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [31:0]           r_rsp_rdata;

  logic                  w_accept;
  logic                  w_cur_write;
  logic [31:0]           w_cur_addr;
  logic [31:0]           w_cur_wdata;
  logic                  w_cur_err;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic                  w_req_ready_next;
  logic                  w_rsp_valid_next;
  logic [31:0]           w_rsp_rdata_next;
  logic                  w_rsp_err_next;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  // With zero wait states the response is formed on the accept edge itself,
  // so the request fields come straight from the inputs while idle.
  assign w_cur_write = (r_state == S_IDLE) ? i_req_write : r_write;
  assign w_cur_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;

  assign w_cur_err    = (w_cur_addr[1:0] != 2'b00) || ((w_cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_cur_idx    = w_cur_addr[DEPTH_LOG2+1:2];
  assign w_enter_resp = (r_state != S_RESP) && (w_state_next == S_RESP);
  assign w_mem_we     = w_enter_resp && w_cur_write && !w_cur_err;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    w_req_ready_next = (w_state_next == S_IDLE);
    w_rsp_valid_next = (w_state_next == S_RESP);
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    if (w_enter_resp) begin
      if (w_cur_err) begin
        w_rsp_rdata_next = 32'd0;
        w_rsp_err_next   = 1'b1;
      end else if (w_cur_write) begin
        w_rsp_rdata_next = w_cur_wdata;
        w_rsp_err_next   = 1'b0;
      end else begin
        w_rsp_rdata_next = r_mem[w_cur_idx];
        w_rsp_err_next   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_write <= i_req_write;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
    end
  end

  // Memory is cleared by reset, so it lives in flops rather than block RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_mem_we) begin
      r_mem[w_cur_idx] <= w_cur_wdata;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench: instance 0 uses two wait states, instance 1 uses none.
module tb_mc_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  mc_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut_w2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .i_req_write(req_write[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_req_ready(req_ready[0]), .o_rsp_valid(rsp_valid[0]),
    .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  mc_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut_w0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .i_req_write(req_write[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_req_ready(req_ready[1]), .o_rsp_valid(rsp_valid[1]),
    .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   acc_edge [2];
  int   n_acc [2];
  int   exp_acc [2];
  logic seen [2];

  task automatic check32(input string name, input int u, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: got=%h expected=%h", name, u, got, expv);
    end
  endtask

  // Accept bookkeeping: inputs are driven 1 time unit after the edge, outputs
  // update via NBA, so both are stable when sampled here.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_n && req_valid[u] && req_ready[u]) begin
        acc_edge[u] = edge_cnt;
        n_acc[u]++;
      end
    end
    edge_cnt++;
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_n && rsp_valid[u]) begin
        exp_t e;
        logic have;
        have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp dut%0d: got rdata=%h err=%b expected no response", u, rsp_rdata[u], rsp_err[u]);
        end else begin
          e = (u == 0) ? q0[0] : q1[0];
          if (!seen[u]) begin
            check32("latency", u, 32'(edge_cnt - acc_edge[u] - 1), 32'(e.lat));
            seen[u] = 1'b1;
          end
          check32("rsp_rdata", u, rsp_rdata[u], e.rdata);
          check32("rsp_err", u, 32'(rsp_err[u]), 32'(e.err));
          check32("req_ready_busy", u, 32'(req_ready[u]), 32'd0);
          if (rsp_ready[u]) begin
            $display("rsp dut%0d: rdata=%h err=%b", u, rsp_rdata[u], rsp_err[u]);
            if (u == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            seen[u] = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int u);
    int k;
    k = 0;
    while (!req_ready[u] && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready[u]) check32("idle_timeout", u, 32'(req_ready[u]), 32'd1);
  endtask

  task automatic issue(input int u, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input logic wait_done);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = (u == 0) ? 4'd2 : 4'd0;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    exp_acc[u]++;
    check32("req_ready_idle", u, 32'(req_ready[u]), 32'd1);
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    if (wait_done) wait_idle(u);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0;
      req_addr[u] = 32'd0; req_wdata[u] = 32'd0;
      rsp_ready[u] = 1'b1; acc_edge[u] = 0;
      n_acc[u] = 0; exp_acc[u] = 0; seen[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check32("reset_req_ready", u, 32'(req_ready[u]), 32'd1);
      check32("reset_rsp_valid", u, 32'(rsp_valid[u]), 32'd0);
      check32("reset_rsp_rdata", u, rsp_rdata[u], 32'd0);
      check32("reset_rsp_err", u, 32'(rsp_err[u]), 32'd0);
    end
    rst_n = 1'b1;

    // Zero-wait-state instance
    issue(1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b1);
    issue(1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_0000, 1'b1, 1'b1);

    // Two-wait-state instance
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(0, 1'b1, 32'h0000_0013, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 1'b1);
    issue(0, 1'b1, 32'h0000_00FC, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_00FC, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1, 1'b1);
    issue(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    issue(0, 1'b1, 32'h0000_0014, 32'h1111_1111, 32'h1111_1111, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1);

    // Backpressure with req_valid toggling while the response is held
    rsp_ready[0] = 1'b0;
    issue(0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);
    k = 0;
    while (!rsp_valid[0] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check32("bp_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h0000_0010;
    req_wdata[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = ~req_valid[0];
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check32("bp_release_req_ready", 0, 32'(req_ready[0]), 32'd1);
    check32("bp_release_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);

    // Reset while a store is waiting
    exp_acc[0]++;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h0000_0020;
    req_wdata[0] = 32'hA5A5_A5A5;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check32("async_rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    check32("async_rst_req_ready", 0, 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check32("sb_empty", 0, 32'(q0.size()), 32'd0);
    check32("sb_empty", 1, 32'(q1.size()), 32'd0);
    check32("accept_count", 0, 32'(n_acc[0]), 32'(exp_acc[0]));
    check32("accept_count", 1, 32'(n_acc[1]), 32'(exp_acc[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_mem_responder.md
MC_MEM_RESPONDER -- requirements
Module: mc_mem_responder

Parameters
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of the number of 32-bit words stored (64 words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, legal range 0..7, meaning the wait states inserted between request accept and response.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  multicycle core presents a memory request.
REQ-006 req_write  input  1  1 = store (MemWrite), 0 = load/fetch.
REQ-007 req_addr  input  32  byte address (IorD-selected PC or ALUOut).
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  core consumes the response (IRWrite/data-latch cycle).
REQ-012 rsp_rdata  output  32  load data; store data echoed for stores; 0 on error.
REQ-013 rsp_err  output  1  request was misaligned or out of range; qualified by rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, rsp_valid only in RESP.
REQ-015 A request SHALL be accepted at a rising edge where req_valid=1 and req_ready=1; req_write, req_addr, req_wdata SHALL be registered at that edge and inputs ignored until return to IDLE.
REQ-016 On accept with WAIT_CYCLES=0, the next state SHALL be RESP; otherwise the next state SHALL be WAIT with a 3-bit down-counter loaded with WAIT_CYCLES-1.
REQ-017 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL enter RESP at the edge where the counter equals 0; rsp_valid therefore rises immediately after edge E0+WAIT_CYCLES (E0 = accept edge), or after E0 when WAIT_CYCLES=0.
REQ-018 A request SHALL be in error when addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0; the word index SHALL be addr[DEPTH_LOG2+1:2].
REQ-019 On entering RESP for a valid store, mem[index] SHALL be updated with the registered wdata, and rsp_rdata SHALL equal that wdata.
REQ-020 On entering RESP for a valid load, rsp_rdata SHALL equal mem[index] as of that edge.
REQ-021 For an error request, memory SHALL NOT be modified, rsp_err SHALL be 1, and rsp_rdata SHALL be 0.
REQ-022 rsp_valid, rsp_rdata, and rsp_err SHALL remain stable in RESP until an edge with rsp_ready=1, at which the FSM SHALL return to IDLE.
REQ-023 The earliest next accept SHALL be the edge after the RESP->IDLE edge; no request is accepted in the same cycle as a response handshake.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect; req_valid held in WAIT/RESP SHALL not be accepted or queued.
REQ-025 All outputs SHALL be driven from registers (no combinational input-to-output path).

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and all memory words to 0.
REQ-027 A transaction in WAIT or RESP when reset asserts SHALL be discarded; a store not yet in RESP SHALL NOT modify memory.
REQ-028 After reset deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-029 Store then load, WAIT_CYCLES=2: store addr 0x10 data 0xDEADBEEF, then load 0x10 -> each rsp_valid rises 2 edges after accept, load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-030 WAIT_CYCLES=0 load of addr 0x0 after reset -> rsp_valid high right after the accept edge, rsp_rdata=0x00000000.
REQ-031 Misaligned store addr 0x13 data 0x1234, then load 0x10 -> first rsp_err=1, rsp_rdata=0; load returns the prior contents unchanged.
REQ-032 Out-of-range load addr 0x100 (DEPTH_LOG2=6) -> rsp_err=1, rsp_rdata=0.
REQ-033 Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid -> rsp outputs stable, req_ready=0, no second accept; rsp_ready=1 -> IDLE next edge.
REQ-034 Reset mid-store: assert reset in WAIT of store 0x20=0xA5A5A5A5, release, load 0x20 -> rsp_rdata=0x00000000.
